// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM states, Booth operation codes
// and the recoding helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OP    = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } estado_t;

  localparam logic [1:0] NOP   = 2'd0;
  localparam logic [1:0] SUMA  = 2'd1;
  localparam logic [1:0] RESTA = 2'd2;

  function automatic logic [1:0] booth_op(input logic q0, input logic qsub1);
    case ({q0, qsub1})
      2'b10:   booth_op = RESTA;
      2'b01:   booth_op = SUMA;
      default: booth_op = NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_camino_datos.sv
// Booth datapath: A/M/Q/qsub1 registers, add/subtract unit and a variable arithmetic right
// shifter over {A,Q,qsub1}.
module booth_camino_datos #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CargaQ,
  input  logic               CargaM,
  input  logic               CargaA,
  input  logic               LimpiaA,
  input  logic               Resta,
  input  logic               DesplazaAQ,
  input  logic [CNT_W-1:0]   desplazamiento,
  input  logic [WIDTH-1:0]   multiplicando,
  input  logic [WIDTH-1:0]   multiplicador,
  output logic [WIDTH-1:0]   q,
  output logic               qsub1,
  output logic [2*WIDTH-1:0] producto_desp
);

  logic [WIDTH:0]          a_r;
  logic [WIDTH:0]          m_r;
  logic [WIDTH-1:0]        q_r;
  logic                    qsub1_r;
  logic [WIDTH:0]          suma_s;
  logic signed [2*WIDTH+1:0] cadena_s;
  logic [2*WIDTH+1:0]      desp_s;

  // M is one bit wider than the operand so that negating the most negative value cannot overflow
  assign suma_s        = Resta ? (a_r - m_r) : (a_r + m_r);
  assign cadena_s      = {a_r, q_r, qsub1_r};
  assign desp_s        = cadena_s >>> desplazamiento;
  assign producto_desp = desp_s[2*WIDTH:1];
  assign q             = q_r;
  assign qsub1         = qsub1_r;

  // Operand, accumulator and multiplier registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r     <= {(WIDTH+1){1'b0}};
      m_r     <= {(WIDTH+1){1'b0}};
      q_r     <= {WIDTH{1'b0}};
      qsub1_r <= 1'b0;
    end else begin
      if (CargaM) begin
        m_r <= {multiplicando[WIDTH-1], multiplicando};
      end
      if (LimpiaA) begin
        a_r <= {(WIDTH+1){1'b0}};
      end else if (CargaA) begin
        a_r <= suma_s;
      end else if (DesplazaAQ) begin
        a_r <= desp_s[2*WIDTH+1:WIDTH+1];
      end
      if (CargaQ) begin
        q_r     <= multiplicador;
        qsub1_r <= 1'b0;
      end else if (DesplazaAQ) begin
        q_r     <= desp_s[WIDTH:1];
        qsub1_r <= desp_s[0];
      end
    end
  end

endmodule

// File: rtl/booth_multiplicador_n.sv
// Sequential signed radix-2 Booth multiplier with start/busy/Fin handshake.
// Optional macro BOOTH_EARLY_FIN_EN collapses the remaining shifts once no add/sub can occur.
module booth_multiplicador_n
  import booth_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicando,
  input  logic [WIDTH-1:0]   multiplicador,
  output logic [2*WIDTH-1:0] producto,
  output logic               busy,
  output logic               Fin
);

  estado_t              state_r, state_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     rem_s;
  logic [CNT_W-1:0]     desp_s;
  logic [1:0]           op_s;
  logic                 carga_s, carga_a_s, resta_s, desplaza_s, temprano_s;
  logic [WIDTH-1:0]     q_s;
  logic                 qsub1_s;
  logic [2*WIDTH-1:0]   producto_desp_s;

  assign rem_s = CNT_W'(WIDTH) - cnt_r;

`ifdef BOOTH_EARLY_FIN_EN
  logic [WIDTH-1:0] mascara_s;
  // After cnt shifts only the low WIDTH-cnt bits of Q are still unconsumed multiplier bits
  assign mascara_s  = {WIDTH{1'b1}} >> cnt_r;
  assign temprano_s = (((q_s ^ {WIDTH{qsub1_s}}) & mascara_s) == {WIDTH{1'b0}});
`else
  assign temprano_s = 1'b0;
`endif

  // Next-state and datapath control decode
  always_comb begin
    state_s    = state_r;
    op_s       = NOP;
    carga_s    = 1'b0;
    carga_a_s  = 1'b0;
    resta_s    = 1'b0;
    desplaza_s = 1'b0;
    desp_s     = CNT_W'(1);
    case (state_r)
      IDLE: begin
        if (start) begin
          carga_s = 1'b1;
          state_s = OP;
        end else begin
          state_s = IDLE;
        end
      end
      OP: begin
        op_s      = booth_op(q_s[0], qsub1_s);
        carga_a_s = (op_s != NOP);
        resta_s   = (op_s == RESTA);
        state_s   = SHIFT;
      end
      SHIFT: begin
        desplaza_s = 1'b1;
        // An early finish is only seen when the preceding OP was a NOP, so A is already final
        if (temprano_s) begin
          desp_s  = rem_s;
          state_s = DONE;
        end else if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_s = DONE;
        end else begin
          state_s = OP;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, iteration counter and registered handshake/product outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      producto <= {(2*WIDTH){1'b0}};
      busy     <= 1'b0;
      Fin      <= 1'b0;
    end else begin
      state_r <= state_s;
      if (carga_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (desplaza_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      busy <= (state_s == OP) || (state_s == SHIFT);
      Fin  <= (state_s == DONE);
      if (state_s == DONE) begin
        producto <= producto_desp_s;
      end
    end
  end

  booth_camino_datos #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_camino (
    .clk            (clk),
    .reset          (reset),
    .CargaQ         (carga_s),
    .CargaM         (carga_s),
    .CargaA         (carga_a_s),
    .LimpiaA        (carga_s),
    .Resta          (resta_s),
    .DesplazaAQ     (desplaza_s),
    .desplazamiento (desp_s),
    .multiplicando  (multiplicando),
    .multiplicador  (multiplicador),
    .q              (q_s),
    .qsub1          (qsub1_s),
    .producto_desp  (producto_desp_s)
  );

endmodule

// File: tb/tb_booth_multiplicador_n.sv
// Self-checking bench for booth_multiplicador_n (WIDTH=4 and WIDTH=8 instances) with a
// product scoreboard; expected latency follows BOOTH_EARLY_FIN_EN when defined.
module tb_booth_multiplicador_n;

`ifdef BOOTH_EARLY_FIN_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start4, busy4, fin4;
  logic [3:0]  m4, q4;
  logic [7:0]  p4;
  logic        start8, busy8, fin8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;
  logic [7:0]  sb4[$];
  logic [15:0] sb8[$];

  booth_multiplicador_n #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .multiplicando(m4), .multiplicador(q4),
    .producto(p4), .busy(busy4), .Fin(fin4)
  );

  booth_multiplicador_n #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .multiplicando(m8), .multiplicador(q8),
    .producto(p8), .busy(busy8), .Fin(fin8)
  );

  // Edges from accept to DONE: first iteration c whose remaining multiplier bits all equal
  // the previous bit finishes at 2c+2 when early finish is enabled, otherwise 2*w.
  function automatic int lat_exp(input logic [31:0] q, input int w);
    for (int c = 0; c < w; c++) begin
      logic prev;
      logic ok;
      prev = (c == 0) ? 1'b0 : q[c-1];
      ok   = 1'b1;
      for (int b = c; b < w; b++) if (q[b] !== prev) ok = 1'b0;
      if (EARLY && ok) return 2*c + 2;
    end
    return 2*w;
  endfunction

  function automatic logic [7:0] mult4(input logic [3:0] m, input logic [3:0] q);
    logic signed [7:0] r;
    r = $signed({{4{m[3]}}, m}) * $signed({{4{q[3]}}, q});
    return r;
  endfunction

  task automatic issue4(input logic [3:0] m, input logic [3:0] q);
    @(negedge clk);
    m4 = m; q4 = q; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    sb4.push_back(mult4(m, q));
  endtask

  task automatic wait_fin4(output int lat, output int bc, output logic seen);
    lat = 0; bc = 0; seen = 1'b0;
    if (busy4) bc++;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (fin4) seen = 1'b1;
      else if (busy4) bc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start4 = 1'b0; start8 = 1'b0;
    m4 = 4'h0; q4 = 4'h0; m8 = 8'h00; q8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (p4 !== 8'h00)  begin errors++; $display("FAIL reset_p4: got %h want 00", p4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4: got %b want 0", busy4); end
    checks++; if (fin4 !== 1'b0)  begin errors++; $display("FAIL reset_fin4: got %b want 0", fin4); end
    checks++; if (p8 !== 16'h0000) begin errors++; $display("FAIL reset_p8: got %h want 0000", p8); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_basic;
    int tm[8] = '{3, -8, 7, 5, 3, 0, -1, -8};
    int tq[8] = '{-2, -8, 7, 0, 1, 5, -1, 7};
    for (int i = 0; i < 12; i++) begin
      logic [3:0] m, q;
      logic [7:0] exp;
      int lat, bc;
      logic seen;
      if (i < 8) begin m = 4'(tm[i]); q = 4'(tq[i]); end
      else begin m = 4'($urandom_range(15)); q = 4'($urandom_range(15)); end
      issue4(m, q);
      wait_fin4(lat, bc, seen);
      exp = sb4.pop_front();
      checks++;
      if (!seen) begin errors++; $display("FAIL basic_timeout[%0d]: no Fin within 100 cycles", i); end
      else if (p4 !== exp) begin errors++; $display("FAIL basic_prod[%0d] m=%h q=%h: got %h want %h", i, m, q, p4, exp); end
      checks++;
      if (lat != lat_exp({28'd0, q}, 4)) begin errors++; $display("FAIL basic_lat[%0d]: got %0d want %0d", i, lat, lat_exp({28'd0, q}, 4)); end
      checks++;
      if (bc != lat_exp({28'd0, q}, 4)) begin errors++; $display("FAIL basic_busy[%0d]: got %0d want %0d", i, bc, lat_exp({28'd0, q}, 4)); end
      @(posedge clk); #1;
      checks++;
      if (fin4 !== 1'b0) begin errors++; $display("FAIL basic_fin_pulse[%0d]: got %b want 0", i, fin4); end
    end
  endtask

  task automatic test_w8;
    int lat = 0;
    logic seen = 1'b0;
    logic [15:0] exp;
    @(negedge clk);
    m8 = 8'h80; q8 = 8'h7F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; m8 = 8'h11; q8 = 8'h22;
    sb8.push_back(16'hC080);
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (fin8) seen = 1'b1;
    end
    exp = sb8.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL w8_timeout: no Fin within 100 cycles"); end
    else if (p8 !== exp) begin errors++; $display("FAIL w8_prod: got %h want %h", p8, exp); end
    checks++;
    if (lat != lat_exp(32'h7F, 8)) begin errors++; $display("FAIL w8_lat: got %0d want %0d", lat, lat_exp(32'h7F, 8)); end
  endtask

  task automatic test_ignore_busy;
    int fins = 0, lat = 0, k = 0;
    logic [7:0] got = 8'h00;
    logic [7:0] exp;
    issue4(4'd3, 4'hE);
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      start4 = (k % 2 == 1) && (k < 8);
      m4 = 4'($urandom_range(15)); q4 = 4'($urandom_range(15));
      @(posedge clk); #1;
      if (fin4) begin fins++; got = p4; lat = k; end
    end
    start4 = 1'b0;
    for (k = 9; k <= 30; k++) begin
      @(posedge clk); #1;
      if (fin4) begin fins++; got = p4; lat = k; end
    end
    exp = sb4.pop_front();
    checks++;
    if (fins != 1) begin errors++; $display("FAIL ignore_fin_count: got %0d want 1", fins); end
    checks++;
    if (got !== exp) begin errors++; $display("FAIL ignore_prod: got %h want %h", got, exp); end
    checks++;
    if (lat != lat_exp(32'hE, 4)) begin errors++; $display("FAIL ignore_lat: got %0d want %0d", lat, lat_exp(32'hE, 4)); end
  endtask

  task automatic test_back_to_back;
    int fins = 0, t = 0;
    int tf[2] = '{0, 0};
    logic [7:0] exp;
    @(negedge clk);
    m4 = 4'd7; q4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    sb4.push_back(mult4(4'd7, 4'd7));
    m4 = 4'hB; q4 = 4'd3;
    sb4.push_back(mult4(4'hB, 4'd3));
    while (fins < 2 && t < 80) begin
      @(posedge clk); #1;
      t++;
      if (fin4) begin
        exp = sb4.pop_front();
        tf[fins] = t;
        checks++;
        if (p4 !== exp) begin errors++; $display("FAIL b2b_prod[%0d]: got %h want %h", fins, p4, exp); end
        fins++;
        if (fins == 2) start4 = 1'b0;
      end
    end
    start4 = 1'b0;
    checks++;
    if (fins != 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", fins); end
    checks++;
    if (tf[0] != lat_exp(32'd7, 4)) begin errors++; $display("FAIL b2b_lat0: got %0d want %0d", tf[0], lat_exp(32'd7, 4)); end
    checks++;
    if (tf[1] - tf[0] != lat_exp(32'd3, 4) + 2) begin
      errors++; $display("FAIL b2b_gap: got %0d want %0d", tf[1] - tf[0], lat_exp(32'd3, 4) + 2);
    end
    sb4.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int fins = 0, lat, bc;
    logic seen;
    logic [7:0] exp;
    issue4(4'd5, 4'd3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (p4 !== 8'h00)   begin errors++; $display("FAIL midrst_prod: got %h want 00", p4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy4); end
    checks++; if (fin4 !== 1'b0)  begin errors++; $display("FAIL midrst_fin: got %b want 0", fin4); end
    @(negedge clk) reset = 1'b1;
    sb4.delete();
    repeat (14) begin
      @(posedge clk); #1;
      if (fin4 || busy4) fins++;
    end
    checks++;
    if (fins != 0) begin errors++; $display("FAIL midrst_activity: got %0d want 0", fins); end
    issue4(4'hD, 4'd5);
    wait_fin4(lat, bc, seen);
    exp = sb4.pop_front();
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_timeout: no Fin within 100 cycles"); end
    else if (p4 !== exp) begin errors++; $display("FAIL midrst_new_prod: got %h want %h", p4, exp); end
    checks++;
    if (lat != lat_exp(32'd5, 4)) begin errors++; $display("FAIL midrst_new_lat: got %0d want %0d", lat, lat_exp(32'd5, 4)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w8();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
